turn_sequencer: RTL and testbench
=================================

Name: turn_sequencer

Overview:
- Parametrised game-turn controller for the board-game FPGA design.
- Generalises the single-player control FSM to 2..MAX_PLAYERS players with round-robin turns and per-player track positions.
- Adds on-chip win detection, key-release interlock and an optional per-turn timeout.
- Sits between the keypad decoder and card-match logic upstream, and the display/LED drivers downstream.

Parameters:
- MAX_PLAYERS, 4: maximum players; setup accepts 2..MAX_PLAYERS.
- PLAYER_W, 2: width of player index; clog2(MAX_PLAYERS).
- KEY_W, 4: keypad code width.
- KEY_IDLE, 4'hF: keypad code meaning "no key pressed".
- POS_W, 5: per-player position width.
- TRACK_LEN, 24: track length; finish square is TRACK_LEN-1.
- TIMEOUT, 0: cycles allowed in WAIT_KEY before forced pass; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low: rst=0 at a clk edge resets the block.
- start  in  1  level request to begin a game; also requests a rematch from DONE.
- key  in  KEY_W  keypad code; KEY_IDLE when no key is pressed.
- match_valid  in  1  card-match result strobe.
- match  in  1  match result; sampled only when match_valid=1.
- prompt  out  1  high while waiting for the current player's key.
- step  out  1  one-cycle pulse when the current player advances.
- timeout_pulse  out  1  one-cycle pulse when a turn is forfeited by timeout.
- cur_player  out  PLAYER_W  index of the player whose turn it is.
- num_players  out  PLAYER_W  player count minus 1.
- pick  out  KEY_W  last accepted key code.
- pos_flat  out  MAX_PLAYERS*POS_W  packed positions; player i occupies bits [i*POS_W +: POS_W].
- done  out  1  high while in DONE.
- winner  out  PLAYER_W  winning player index; valid while done=1.
- state  out  3  current FSM state code.

Behaviour:
- General: all outputs registered; state advances only on posedge clk.
- Reset (rst=0 at posedge): state=IDLE; every output 0; armed flag=1; timer=0. Reset mid-game discards all positions.
- State codes: IDLE=0, SETUP=1, ARM=2, WAIT_KEY=3, WAIT_MATCH=4, ADVANCE=5, NEXT=6, DONE=7.
- IDLE: start=1 -> SETUP.
- SETUP: key k with 2<=k<=MAX_PLAYERS -> num_players=k-1, armed=0, go to ARM. Any other code, including KEY_IDLE, 0, 1 and >MAX_PLAYERS, is ignored and the FSM stays in SETUP.
- ARM (1 cycle): all positions=0, cur_player=0, timer=0, winner=0 -> WAIT_KEY.
- Armed flag: set on any cycle where key==KEY_IDLE. Cleared when a key is accepted in SETUP or WAIT_KEY. A held key is never accepted twice.
- WAIT_KEY: prompt=1 on every cycle in this state.
  - Key acceptance: if key!=KEY_IDLE and armed=1, then pick<=key, armed<=0, timer<=0 -> WAIT_MATCH.
  - Timeout: else if TIMEOUT!=0 and timer==TIMEOUT-1, then timeout_pulse=1 for 1 cycle -> NEXT.
  - Otherwise timer increments.
  - Acceptance wins over timeout when both occur in the same cycle.
- WAIT_MATCH: prompt=0; the FSM waits indefinitely for match_valid.
  - match_valid=1 and match=1 -> ADVANCE.
  - match_valid=1 and match=0 -> NEXT.
- ADVANCE (1 cycle): step=1; pos[cur] <= pos[cur]+1, saturating at TRACK_LEN-1.
  - If the new position == TRACK_LEN-1: winner<=cur_player -> DONE.
  - Otherwise -> WAIT_KEY with the same player (a correct match keeps the turn).
- NEXT (1 cycle): cur_player <= (cur_player==num_players) ? 0 : cur_player+1; timer=0 -> WAIT_KEY.
- DONE: done=1; winner and positions held. start=1 -> ARM (rematch, same num_players). Key input is ignored.
- Invariants:
  - step and timeout_pulse never assert together.
  - pos_flat bits for players above num_players stay 0.
- Latency: key accepted -> WAIT_MATCH next cycle; match_valid -> step pulse 1 cycle later; win -> done 2 cycles after the winning match_valid.

Test Plan:
- Reset: rst=0 for 2 cycles with start=1 and key=3 -> state=0, all outputs 0. Release rst, start=1 -> state=1 next cycle.
- Setup filtering: in SETUP, key=1, then 9 (MAX_PLAYERS=4), then 3 -> stays in SETUP for 1 and 9. On 3: num_players=2, ARM, then WAIT_KEY with cur_player=0 and prompt=1.
- Turn rotation: 3 players, each turn key press + release, then match_valid with match=0 -> cur_player sequence 0,1,2,0. No step pulses; positions all 0.
- Key interlock: hold key=5 across acceptance and mismatch into next player's WAIT_KEY -> no second acceptance until key=KEY_IDLE for at least 1 cycle.
- Timeout: TIMEOUT=8, no key pressed -> timeout_pulse exactly 8 cycles after WAIT_KEY entry, cur_player increments. Pressing a key at cycle 7 -> accepted, no pulse.
- Win/rematch: TRACK_LEN=4, player 1 gets 3 consecutive matches -> 3 step pulses, pos[1]=3, done=1, winner=1. Then start=1 -> ARM: positions cleared, cur_player=0, num_players unchanged.

Source files
------------

// File: rtl/turn_sequencer.sv
// turn_sequencer: round-robin game-turn controller for 2..MAX_PLAYERS players with
//   per-player track positions, on-chip win detection, key-release interlock and optional turn timeout.
// Latency: key accept -> WAIT_MATCH next cycle; match_valid -> step 1 cycle later; winning match -> done 2 cycles later.
// Backpressure: none; the FSM parks in WAIT_KEY / WAIT_MATCH until upstream strobes arrive, downstream always accepts.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   start                begin a game from IDLE, or a rematch from DONE
//   key                  keypad code, KEY_IDLE when nothing is pressed
//   match_valid, match   card-match result strobe and value
//   prompt               high while waiting for the current player's key
//   step, timeout_pulse  one-cycle pulses: player advances / turn forfeited
//   cur_player           whose turn it is; num_players = player count - 1
//   pick                 last accepted key code
//   pos_flat             packed positions, player i at [i*POS_W +: POS_W]
//   done, winner         game over and winning player index
//   state                current FSM state code
module turn_sequencer #(
  parameter int               MAX_PLAYERS = 4,
  parameter int               PLAYER_W    = 2,
  parameter int               KEY_W       = 4,
  parameter logic [KEY_W-1:0] KEY_IDLE    = 4'hF,
  parameter int               POS_W       = 5,
  parameter int               TRACK_LEN   = 24,
  parameter int               TIMEOUT     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KEY_W-1:0]             key,
  input  logic                         match_valid,
  input  logic                         match,
  output logic                         prompt,
  output logic                         step,
  output logic                         timeout_pulse,
  output logic [PLAYER_W-1:0]          cur_player,
  output logic [PLAYER_W-1:0]          num_players,
  output logic [KEY_W-1:0]             pick,
  output logic [MAX_PLAYERS*POS_W-1:0] pos_flat,
  output logic                         done,
  output logic [PLAYER_W-1:0]          winner,
  output logic [2:0]                   state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETUP      = 3'd1,
    S_ARM        = 3'd2,
    S_WAIT_KEY   = 3'd3,
    S_WAIT_MATCH = 3'd4,
    S_ADVANCE    = 3'd5,
    S_NEXT       = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  // Timer only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
  localparam logic [POS_W-1:0] FINISH   = POS_W'(TRACK_LEN - 1);

  state_t           fsm;
  logic             armed;
  logic [TMR_W-1:0] timer;

  logic [POS_W-1:0] cur_pos;
  logic [POS_W-1:0] new_pos;
  logic             setup_ok;
  logic             key_take;
  logic             tmo_hit;

  assign state    = fsm;
  assign cur_pos  = pos_flat[cur_player*POS_W +: POS_W];
  // Saturate at the finish square so a stray advance can never wrap.
  assign new_pos  = (cur_pos == FINISH) ? cur_pos : cur_pos + 1'b1;
  assign setup_ok = (int'(key) >= 2) && (int'(key) <= MAX_PLAYERS);
  // Armed guarantees a held key is accepted once; it re-arms only after a release.
  assign key_take = (key != KEY_IDLE) && armed;
  assign tmo_hit  = (TIMEOUT != 0) && (timer == TMR_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm           <= S_IDLE;
      armed         <= 1'b1;
      timer         <= '0;
      prompt        <= 1'b0;
      step          <= 1'b0;
      timeout_pulse <= 1'b0;
      cur_player    <= '0;
      num_players   <= '0;
      pick          <= '0;
      pos_flat      <= '0;
      done          <= 1'b0;
      winner        <= '0;
    end else begin
      step          <= 1'b0;
      timeout_pulse <= 1'b0;
      if (key == KEY_IDLE) armed <= 1'b1;

      // Outputs are set on the transition into the state that owns them,
      // so prompt/step/done are true exactly while that state is current.
      case (fsm)
        S_IDLE: begin
          if (start) fsm <= S_SETUP;
        end

        S_SETUP: begin
          if (setup_ok) begin
            num_players <= PLAYER_W'(key - 1'b1);
            armed       <= 1'b0;
            fsm         <= S_ARM;
          end
        end

        S_ARM: begin
          pos_flat   <= '0;
          cur_player <= '0;
          timer      <= '0;
          winner     <= '0;
          prompt     <= 1'b1;
          fsm        <= S_WAIT_KEY;
        end

        S_WAIT_KEY: begin
          // Acceptance takes priority over a timeout landing on the same cycle.
          if (key_take) begin
            pick   <= key;
            armed  <= 1'b0;
            timer  <= '0;
            prompt <= 1'b0;
            fsm    <= S_WAIT_MATCH;
          end else if (tmo_hit) begin
            timeout_pulse <= 1'b1;
            prompt        <= 1'b0;
            fsm           <= S_NEXT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_WAIT_MATCH: begin
          if (match_valid) begin
            if (match) begin
              step <= 1'b1;
              fsm  <= S_ADVANCE;
            end else begin
              fsm <= S_NEXT;
            end
          end
        end

        S_ADVANCE: begin
          pos_flat[cur_player*POS_W +: POS_W] <= new_pos;
          if (new_pos == FINISH) begin
            winner <= cur_player;
            done   <= 1'b1;
            fsm    <= S_DONE;
          end else begin
            // A correct match keeps the turn with the same player.
            prompt <= 1'b1;
            fsm    <= S_WAIT_KEY;
          end
        end

        S_NEXT: begin
          cur_player <= (cur_player == num_players) ? '0 : cur_player + 1'b1;
          timer      <= '0;
          prompt     <= 1'b1;
          fsm        <= S_WAIT_KEY;
        end

        S_DONE: begin
          if (start) begin
            done <= 1'b0;
            fsm  <= S_ARM;
          end
        end

        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;
  localparam int          MAXP = 4;
  localparam int          POSW = 5;
  localparam int          TL   = 4;
  localparam int          TO   = 8;
  localparam logic [3:0]  IDLE_K = 4'hF;
  localparam int          K_PROMPT = 0, K_STEP = 1, K_TMO = 2, K_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  key = 4'hF;
  logic        match_valid = 1'b0;
  logic        match = 1'b0;
  logic        prompt, step, timeout_pulse, done;
  logic [1:0]  cur_player, num_players, winner;
  logic [3:0]  pick;
  logic [19:0] pos_flat;
  logic [2:0]  state;

  turn_sequencer #(
    .MAX_PLAYERS(MAXP), .PLAYER_W(2), .KEY_W(4), .KEY_IDLE(4'hF),
    .POS_W(POSW), .TRACK_LEN(TL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .match_valid(match_valid), .match(match),
    .prompt(prompt), .step(step), .timeout_pulse(timeout_pulse),
    .cur_player(cur_player), .num_players(num_players), .pick(pick),
    .pos_flat(pos_flat), .done(done), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model: game rules only ----------------
  typedef struct { int kind; int player; logic [19:0] flat; } ev_t;
  ev_t exp_q[$];
  int  mpos[MAXP];
  int  mcur = 0;
  int  mn   = 3;

  function automatic logic [19:0] mflat();
    logic [19:0] f = '0;
    for (int i = 0; i < MAXP; i++) f[i*POSW +: POSW] = POSW'(mpos[i]);
    return f;
  endfunction

  function automatic void push(input int kind, input int who);
    ev_t e;
    e.kind = kind; e.player = who; e.flat = mflat();
    exp_q.push_back(e);
  endfunction

  function automatic void model_arm();
    for (int i = 0; i < MAXP; i++) mpos[i] = 0;
    mcur = 0;
    push(K_PROMPT, 0);
  endfunction

  function automatic void model_mismatch();
    mcur = (mcur + 1) % mn;
    push(K_PROMPT, mcur);
  endfunction

  function automatic void model_timeout();
    push(K_TMO, mcur);
    mcur = (mcur + 1) % mn;
    push(K_PROMPT, mcur);
  endfunction

  function automatic logic model_match();
    mpos[mcur] = (mpos[mcur] + 1 > TL - 1) ? TL - 1 : mpos[mcur] + 1;
    push(K_STEP, mcur);
    if (mpos[mcur] == TL - 1) begin
      push(K_DONE, mcur);
      return 1'b1;
    end
    push(K_PROMPT, mcur);
    return 1'b0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic take(input int kind, input int who, output logic [19:0] flat);
    ev_t e;
    flat = '0;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: DUT event kind %0d player %0d, model expected none", kind, who);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_player", who, e.player);
      flat = e.flat;
    end
  endtask

  initial begin : monitor
    logic        pp, pd, pend;
    logic [19:0] pend_flat, f;
    pp = 1'b0; pd = 1'b0; pend = 1'b0; pend_flat = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("step_pos", 32'(pos_flat), 32'(pend_flat));
        pend = 1'b0;
      end
      if (step || timeout_pulse) chk("step_tmo_excl", 32'(step & timeout_pulse), 0);
      if (prompt && !pp) take(K_PROMPT, int'(cur_player), f);
      if (step) begin
        take(K_STEP, int'(cur_player), f);
        pend = 1'b1; pend_flat = f;
      end
      if (timeout_pulse) take(K_TMO, int'(cur_player), f);
      if (done && !pd) begin
        take(K_DONE, int'(winner), f);
        chk("done_pos", 32'(pos_flat), 32'(f));
      end
      pp = prompt; pd = done;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_prompt();
    int n = 0;
    while (!prompt && n < 40) begin @(negedge clk); n++; end
    chk("prompt_wait", 32'(prompt), 1);
  endtask

  task automatic press_key(input logic [3:0] k);
    key = k;
    @(negedge clk);
    chk("accept_state", 32'(state), 4);
    chk("accept_pick", 32'(pick), 32'(k));
    key = IDLE_K;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic do_match(input logic m, input logic won);
    match_valid = 1'b1; match = m;
    @(negedge clk);
    match_valid = 1'b0; match = 1'($urandom_range(0, 1));
    if (m) chk("step_latency", 32'(step), 1);
    else   chk("nomatch_state", 32'(state), 6);
    if (won) begin
      @(negedge clk);
      chk("done_latency", 32'(done), 1);
      chk("done_state", 32'(state), 7);
    end
  endtask

  task automatic wait_timeout();
    int n = 0;
    while (!timeout_pulse && n < 20) begin @(negedge clk); n++; end
    chk("tmo_latency", n, TO);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    logic won, m;
    int   r;

    // Reset with start and a valid setup key held.
    rst = 1'b0; start = 1'b1; key = 4'h3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", 32'({prompt, step, timeout_pulse, done, cur_player, num_players, winner, pick}), 0);
    chk("rst_pos", 32'(pos_flat), 0);

    rst = 1'b1; key = IDLE_K; start = 1'b1;
    @(negedge clk); chk("idle_to_setup", 32'(state), 1);

    // Setup filtering.
    start = 1'b0; key = 4'h1;
    @(negedge clk); chk("setup_key1", 32'(state), 1);
    key = 4'h9;
    @(negedge clk); chk("setup_key9", 32'(state), 1);
    mn = 3; model_arm();
    key = 4'h3;
    @(negedge clk);
    chk("setup_to_arm", 32'(state), 2);
    chk("setup_np", 32'(num_players), 2);
    key = IDLE_K;
    wait_prompt();
    chk("first_state", 32'(state), 3);
    chk("first_player", 32'(cur_player), 0);

    // Turn rotation with mismatches: prompts 0,1,2,0.
    for (int t = 0; t < 3; t++) begin
      press_key(4'($urandom_range(0, 14)));
      model_mismatch();
      do_match(1'b0, 1'b0);
      wait_prompt();
    end
    chk("rot_player", 32'(cur_player), 0);
    chk("rot_pos", 32'(pos_flat), 0);

    // Key interlock: held key is not accepted by the next player.
    key = 4'h5;
    @(negedge clk);
    chk("hold_accept", 32'(state), 4);
    model_mismatch();
    do_match(1'b0, 1'b0);
    wait_prompt();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("interlock_hold", 32'(state), 3);
    end
    key = IDLE_K;
    @(negedge clk); chk("interlock_release", 32'(state), 3);
    key = 4'h5;
    @(negedge clk); chk("interlock_reaccept", 32'(state), 4);
    key = IDLE_K;
    model_mismatch();
    do_match(1'b0, 1'b0);
    wait_prompt();

    // Timeout: player 2 presses nothing.
    model_timeout();
    wait_timeout();
    wait_prompt();
    chk("tmo_next_player", 32'(cur_player), 0);

    // Key at the last possible cycle beats the timeout.
    repeat (TO - 1) @(negedge clk);
    key = 4'h3;
    @(negedge clk);
    chk("late_accept_state", 32'(state), 4);
    chk("late_no_pulse", 32'(timeout_pulse), 0);
    key = IDLE_K;
    model_mismatch();
    do_match(1'b0, 1'b0);
    wait_prompt();

    // Player 1 wins with three consecutive matches.
    won = 1'b0;
    for (int i = 0; i < 3; i++) begin
      press_key(4'($urandom_range(0, 14)));
      won = model_match();
      do_match(1'b1, won);
      if (!won) wait_prompt();
    end
    chk("win_done", 32'(done), 1);
    chk("win_winner", 32'(winner), 1);
    chk("win_pos", 32'(pos_flat), 32'(20'(TL - 1) << POSW));

    // Rematch keeps the player count and clears the board.
    model_arm();
    start = 1'b1;
    @(negedge clk);
    chk("rematch_arm", 32'(state), 2);
    chk("rematch_done_low", 32'(done), 0);
    start = 1'b0;
    wait_prompt();
    chk("rematch_pos", 32'(pos_flat), 0);
    chk("rematch_player", 32'(cur_player), 0);
    chk("rematch_np", 32'(num_players), 2);

    // Randomized game against the model.
    won = 1'b0;
    for (int t = 0; t < 60 && !won; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        model_timeout();
        wait_timeout();
        wait_prompt();
      end else begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        press_key(4'($urandom_range(0, 14)));
        m = ($urandom_range(0, 9) < 6);
        if (m) won = model_match();
        else model_mismatch();
        do_match(m, won);
        if (!won) wait_prompt();
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
